// File: rtl/mem_access_stage.sv
// Memory-access stage for the IITK-MIPS datapath: runs LW/LB/LBU/SW/SB against a
// variable-latency data memory over a req/ack handshake and returns register writeback.
module mem_access_stage #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [5:0]        opcode_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       store_data_i,
  input  logic [4:0]        dest_reg_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              wb_en_o,
  output logic [4:0]        wb_reg_o,
  output logic [31:0]       wb_data_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SB  = 6'h28;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e              state_q, state_d;
  logic [5:0]          opcode_q, opcode_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         storeData_q, storeData_d;
  logic [4:0]          destReg_q, destReg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                wbEn_q, wbEn_d;
  logic [4:0]          wbReg_q, wbReg_d;
  logic [31:0]         wbData_q, wbData_d;

  logic                inIsMem, inMisaligned, qIsLoad, qIsStore;
  logic [7:0]          loadByte;
  logic [31:0]         loadVal;
  logic                unusedAddrHi;

  // The word address only needs the low bits; the rest of the ALU result is ignored.
  assign unusedAddrHi = |addr_i[31:ADDR_W+2];

  always_comb begin
    inIsMem      = (opcode_i == OP_LW) || (opcode_i == OP_LB) || (opcode_i == OP_LBU) ||
                   (opcode_i == OP_SW) || (opcode_i == OP_SB);
    inMisaligned = ((opcode_i == OP_LW) || (opcode_i == OP_SW)) && (addr_i[1:0] != 2'b00);
    qIsLoad      = (opcode_q == OP_LW) || (opcode_q == OP_LB) || (opcode_q == OP_LBU);
    qIsStore     = (opcode_q == OP_SW) || (opcode_q == OP_SB);
  end

  always_comb begin
    case (addr_q[1:0])
      2'd1:    loadByte = mem_rdata_i[15:8];
      2'd2:    loadByte = mem_rdata_i[23:16];
      2'd3:    loadByte = mem_rdata_i[31:24];
      default: loadByte = mem_rdata_i[7:0];
    endcase
    if (opcode_q == OP_LW)      loadVal = mem_rdata_i;
    else if (opcode_q == OP_LB) loadVal = {{24{loadByte[7]}}, loadByte};
    else                        loadVal = {24'h0, loadByte};
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    storeData_d = storeData_q;
    destReg_d   = destReg_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    wbEn_d      = wbEn_q;
    wbReg_d     = wbReg_q;
    wbData_d    = wbData_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          opcode_d    = opcode_i;
          addr_d      = addr_i[ADDR_W+1:0];
          storeData_d = store_data_i;
          destReg_d   = dest_reg_i;
          cnt_d       = '0;
          if (inIsMem && !inMisaligned) begin
            state_d = REQ;
          end else begin
            state_d  = DONE;
            err_d    = inMisaligned;
            wbEn_d   = 1'b0;
            wbReg_d  = dest_reg_i;
            wbData_d = 32'h0;
          end
        end
      end
      REQ: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_ack_i) begin
          state_d  = DONE;
          err_d    = 1'b0;
          wbEn_d   = qIsLoad;
          wbReg_d  = destReg_q;
          wbData_d = qIsLoad ? loadVal : 32'h0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == TIMEOUT_CNT) begin
            state_d  = DONE;
            err_d    = 1'b1;
            wbEn_d   = 1'b0;
            wbReg_d  = destReg_q;
            wbData_d = 32'h0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      opcode_q    <= '0;
      addr_q      <= '0;
      storeData_q <= '0;
      destReg_q   <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      wbEn_q      <= 1'b0;
      wbReg_q     <= '0;
      wbData_q    <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      storeData_q <= storeData_d;
      destReg_q   <= destReg_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      wbEn_q      <= wbEn_d;
      wbReg_q     <= wbReg_d;
      wbData_q    <= wbData_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign err_o     = (state_q == DONE) && err_q;
  assign wb_en_o   = (state_q == DONE) && wbEn_q;
  assign wb_reg_o  = wbReg_q;
  assign wb_data_o = wbData_q;

  // Memory-side outputs are driven from latched state only, so they stay fixed for the whole request.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = 4'h0;
    mem_wdata_o = 32'h0;
    if (state_q == REQ) begin
      mem_req_o  = 1'b1;
      mem_we_o   = qIsStore;
      mem_addr_o = addr_q[ADDR_W+1:2];
      if (opcode_q == OP_SB) begin
        mem_be_o    = 4'b0001 << addr_q[1:0];
        mem_wdata_o = {4{storeData_q[7:0]}};
      end else begin
        mem_be_o    = 4'hF;
        mem_wdata_o = (opcode_q == OP_SW) ? storeData_q : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench for mem_access_stage with a behavioural
// variable-latency memory responder.
module tb_mem_access_stage;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SB  = 6'h28;

  logic        clk, reset, start;
  logic [5:0]  opcode;
  logic [31:0] addr, storeData;
  logic [4:0]  destReg;
  logic        busy, done, err, wbEn;
  logic [4:0]  wbReg;
  logic [31:0] wbData;
  logic        memReq, memWe, memAck;
  logic [9:0]  memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWdata, memRdata;

  mem_access_stage #(.ADDR_W(10), .TIMEOUT(16)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .opcode_i(opcode),
    .addr_i(addr), .store_data_i(storeData), .dest_reg_i(destReg),
    .busy_o(busy), .done_o(done), .err_o(err), .wb_en_o(wbEn),
    .wb_reg_o(wbReg), .wb_data_o(wbData), .mem_req_o(memReq), .mem_we_o(memWe),
    .mem_addr_o(memAddr), .mem_be_o(memBe), .mem_wdata_o(memWdata),
    .mem_ack_i(memAck), .mem_rdata_i(memRdata)
  );

  typedef struct {
    logic        err;
    logic        wbEn;
    logic [4:0]  wbReg;
    logic [31:0] wbData;
    logic        chkData;
    int          latency;
  } expT;

  expT         expQ[$];
  int          compareCount = 0;
  int          failCount = 0;
  int          cycleNo = 0;
  int          issueCycle = 0;
  logic [31:0] bmem [0:1023];
  logic        ackEnable;
  int          ackDelay, waitCnt, ackCount, reqCycles;
  logic [3:0]  lastBe;
  logic [31:0] lastWdata;
  logic [9:0]  lastAddr;
  logic        lastWe;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Memory responder: acks after ackDelay wait cycles, reads/writes the bench memory on ack.
  initial begin
    memAck = 1'b0; memRdata = 32'h0; waitCnt = 0; ackCount = 0; reqCycles = 0;
    lastBe = 4'h0; lastWdata = 32'h0; lastAddr = '0; lastWe = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (memReq) begin
        reqCycles++;
        if (ackEnable && waitCnt >= ackDelay && !memAck) begin
          memAck = 1'b1;
          ackCount++;
          lastBe = memBe; lastWdata = memWdata; lastAddr = memAddr; lastWe = memWe;
          if (memWe) begin
            for (int b = 0; b < 4; b++)
              if (memBe[b]) bmem[memAddr][8*b +: 8] = memWdata[8*b +: 8];
          end else begin
            memRdata = bmem[memAddr];
          end
        end else begin
          memAck = 1'b0;
          waitCnt++;
        end
      end else begin
        memAck = 1'b0;
        waitCnt = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                               input logic [4:0] dr);
    @(posedge clk);
    #1;
    opcode = op; addr = a; storeData = sd; destReg = dr; start = 1'b1;
    @(posedge clk);
    #1;
    issueCycle = cycleNo;
    start = 1'b0;
  endtask

  function automatic expT mkExp(logic e, logic w, logic [4:0] r, logic [31:0] d, logic c, int lat);
    expT x;
    x.err = e; x.wbEn = w; x.wbReg = r; x.wbData = d; x.chkData = c; x.latency = lat;
    return x;
  endfunction

  task automatic issueOp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] dr, input expT e);
    expQ.push_back(e);
    applyStimulus(op, a, sd, dr);
  endtask

  task automatic collectOp(input string tag);
    logic seen;
    expT  e;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    e = expQ.pop_front();
    if (!seen) begin
      checkOutput({tag, "_doneTimeout"}, 32'(done), 32'h1);
    end else begin
      checkOutput({tag, "_err"}, 32'(err), 32'(e.err));
      checkOutput({tag, "_wbEn"}, 32'(wbEn), 32'(e.wbEn));
      if (e.wbEn) checkOutput({tag, "_wbReg"}, 32'(wbReg), 32'(e.wbReg));
      if (e.chkData) checkOutput({tag, "_wbData"}, wbData, e.wbData);
      checkOutput({tag, "_latency"}, 32'(cycleNo - issueCycle + 2), 32'(e.latency));
    end
  endtask

  initial begin
    int  reqBefore, ackBefore;
    logic doneSeen;
    reset = 1'b1; start = 1'b0; opcode = '0; addr = '0; storeData = '0; destReg = '0;
    ackEnable = 1'b1; ackDelay = 0;
    for (int i = 0; i < 1024; i++) bmem[i] = 32'h0;
    bmem[4] = 32'hDEADBEEF;
    bmem[0] = 32'h00800000;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_memReq", 32'(memReq), 32'h0);
    checkOutput("reset_wbData", wbData, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Word load with one wait cycle
    ackDelay = 1;
    issueOp(OP_LW, 32'h10, 32'h0, 5'd7, mkExp(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 4));
    collectOp("lw_aligned");
    @(negedge clk);
    checkOutput("after_done_pulse", 32'(done), 32'h0);
    checkOutput("after_done_busy", 32'(busy), 32'h0);

    // Byte store to lane 3, then read back the merged word
    ackDelay = 0;
    issueOp(OP_SB, 32'h13, 32'h000000A5, 5'd2, mkExp(1'b0, 1'b0, 5'd2, 32'h0, 1'b1, 3));
    collectOp("sb_lane3");
    checkOutput("sb_be", 32'(lastBe), 32'h8);
    checkOutput("sb_wdata", lastWdata, 32'hA5A5A5A5);
    checkOutput("sb_addr", 32'(lastAddr), 32'h4);
    checkOutput("sb_we", 32'(lastWe), 32'h1);
    issueOp(OP_LW, 32'h10, 32'h0, 5'd8, mkExp(1'b0, 1'b1, 5'd8, 32'hA5ADBEEF, 1'b1, 3));
    collectOp("lw_after_sb");

    issueOp(OP_SW, 32'h14, 32'h12345678, 5'd3, mkExp(1'b0, 1'b0, 5'd3, 32'h0, 1'b1, 3));
    collectOp("sw_aligned");
    checkOutput("sw_be", 32'(lastBe), 32'hF);
    checkOutput("sw_wdata", lastWdata, 32'h12345678);
    checkOutput("sw_addr", 32'(lastAddr), 32'h5);
    issueOp(OP_LB, 32'h15, 32'h0, 5'd10, mkExp(1'b0, 1'b1, 5'd10, 32'h00000056, 1'b1, 3));
    collectOp("lb_lane1");
    issueOp(OP_LBU, 32'h17, 32'h0, 5'd11, mkExp(1'b0, 1'b1, 5'd11, 32'h00000012, 1'b1, 3));
    collectOp("lbu_lane3");

    // Sign versus zero extension of the same byte
    issueOp(OP_LB, 32'h2, 32'h0, 5'd4, mkExp(1'b0, 1'b1, 5'd4, 32'hFFFFFF80, 1'b1, 3));
    collectOp("lb_signext");
    issueOp(OP_LBU, 32'h2, 32'h0, 5'd5, mkExp(1'b0, 1'b1, 5'd5, 32'h00000080, 1'b1, 3));
    collectOp("lbu_zeroext");
    issueOp(OP_LB, 32'h3, 32'h0, 5'd6, mkExp(1'b0, 1'b1, 5'd6, 32'h00000000, 1'b1, 3));
    collectOp("lb_oddaddr");

    // Misaligned word accesses and non-memory opcodes never touch memory
    reqBefore = reqCycles;
    issueOp(OP_LW, 32'h6, 32'h0, 5'd12, mkExp(1'b1, 1'b0, 5'd12, 32'h0, 1'b0, 2));
    collectOp("lw_misaligned");
    issueOp(OP_SW, 32'h1, 32'hFFFFFFFF, 5'd13, mkExp(1'b1, 1'b0, 5'd13, 32'h0, 1'b0, 2));
    collectOp("sw_misaligned");
    issueOp(6'h00, 32'h8, 32'h0, 5'd14, mkExp(1'b0, 1'b0, 5'd14, 32'h0, 1'b0, 2));
    collectOp("nonmem_op");
    checkOutput("no_req_cycles", 32'(reqCycles - reqBefore), 32'h0);

    // Timeout: request held for TIMEOUT cycles, then a normal op is accepted
    ackEnable = 1'b0;
    reqBefore = reqCycles;
    issueOp(OP_LW, 32'h20, 32'h0, 5'd3, mkExp(1'b1, 1'b0, 5'd3, 32'h0, 1'b0, 18));
    collectOp("timeout");
    checkOutput("timeout_req_cycles", 32'(reqCycles - reqBefore), 32'd16);
    ackEnable = 1'b1;
    issueOp(OP_LBU, 32'h11, 32'h0, 5'd15, mkExp(1'b0, 1'b1, 5'd15, 32'h000000BE, 1'b1, 3));
    collectOp("after_timeout");

    // A start pulsed while busy must be dropped
    ackDelay = 3;
    ackBefore = ackCount;
    issueOp(OP_LW, 32'h10, 32'h0, 5'd9, mkExp(1'b0, 1'b1, 5'd9, 32'hA5ADBEEF, 1'b1, 6));
    @(posedge clk);
    #1;
    opcode = OP_SW; addr = 32'h40; storeData = 32'hCAFEF00D; destReg = 5'd20; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    collectOp("busy_start_ignored");
    repeat (3) @(negedge clk);
    checkOutput("busy_start_acks", 32'(ackCount - ackBefore), 32'h1);
    checkOutput("busy_start_idle", 32'(busy), 32'h0);
    checkOutput("busy_start_nowrite", bmem[16], 32'h0);

    // Asynchronous reset in the middle of a request
    ackEnable = 1'b0;
    ackDelay = 0;
    applyStimulus(OP_LW, 32'h10, 32'h0, 5'd1);
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_req", 32'(memReq), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_req", 32'(memReq), 32'h0);
    checkOutput("async_reset_busy", 32'(busy), 32'h0);
    checkOutput("async_reset_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    ackEnable = 1'b1;
    doneSeen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) doneSeen = 1'b1;
    end
    checkOutput("reset_no_done", 32'(doneSeen), 32'h0);
    issueOp(OP_LBU, 32'h10, 32'h0, 5'd1, mkExp(1'b0, 1'b1, 5'd1, 32'h000000EF, 1'b1, 3));
    collectOp("after_reset");
    checkOutput("queue_empty", 32'(expQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
